i_mem_arbiter: RTL and testbench
================================

Name: i_mem_arbiter

Overview:
- Shares one instruction-memory port between two requesters: m0, the CPU instruction fetch (read-only), and m1, the program loader/debug port (read/write).
- Sits between the requesters and the memory block, and uses the same req/ack handshake on all sides: requester holds req until ack.
- Fair round-robin arbitration, optional m1 lock for bursts, forced idle gap between transactions, watchdog timeout.

Parameters:
- ADDR_WIDTH, 16, address width of all ports.
- DATA_WIDTH, 8, data width of all ports.
- TIMEOUT_CYCLES, 1024, cycles in a grant state without s_ack before the transaction is aborted; 0 disables the watchdog.

Ports:
- clk  in  1  single clock, rising edge
- rst  in  1  synchronous, active-high reset
- m0_req  in  1  fetch request
- m0_addr  in  ADDR_WIDTH  fetch address
- m0_ack  out  1  fetch complete; m0_rdata valid this cycle
- m0_rdata  out  DATA_WIDTH  fetch data
- m1_req  in  1  loader request
- m1_we  in  1  1 = write, 0 = read
- m1_lock  in  1  keep grant across back-to-back m1 transactions
- m1_addr  in  ADDR_WIDTH  loader address
- m1_wdata  in  DATA_WIDTH  loader write data
- m1_ack  out  1  loader transaction complete
- m1_rdata  out  DATA_WIDTH  loader read data
- s_req  out  1  request to memory
- s_we  out  1  write enable to memory
- s_addr  out  ADDR_WIDTH  memory address
- s_wdata  out  DATA_WIDTH  memory write data
- s_ack  in  1  memory ack; asserted only while s_req is high
- s_rdata  in  DATA_WIDTH  memory read data
- err  out  1  one-cycle pulse on watchdog abort
- err_src  out  1  requester aborted by the last timeout (0 = m0, 1 = m1); holds until the next abort

Behaviour:
- Clocking and reset: all state updates on the rising edge of clk; rst is synchronous and active-high.
- Reset values: state=IDLE, last=1 (so m0 wins the first arbitration), wdog=0, err=0, err_src=0.
- Combinational outputs during reset: s_req=0, s_we=0, m0_ack=0, m1_ack=0.
- States: IDLE, GNT0, GNT1, GAP.
- IDLE, no requests: stay in IDLE.
- IDLE, single request: grant that requester next cycle.
- IDLE, both requesting: grant the requester that is not `last`; on entry set last to the grantee.
- IDLE outputs: s_req=0.
- GNTx muxing: s_addr/s_we/s_wdata come from the granted requester.
  - s_we is forced to 0 in GNT0.
  - Muxed outputs are zero when not granted.
- GNTx request: s_req = mx_req.
- GNTx ack: mx_ack = s_ack & s_req, purely combinational, so it adds no latency beyond the memory's own.
- Ack isolation: the non-granted requester's ack is always 0.
- Read data: m0_rdata and m1_rdata are both driven from s_rdata unconditionally; they are valid only in a cycle where the matching ack is high.
- Completion: s_ack&s_req in GNTx ends the transaction.
  - Default: go to GAP.
  - Exception: GNT1 with m1_lock=1 stays in GNT1. The loader must then drop m1_req for one cycle itself to clear the memory's ready flag.
- GAP: s_req=0 for exactly one cycle, then IDLE.
  - Purpose: the memory's registered ready must fall before a new address is presented. This guarantees no stale ack.
  - Throughput: minimum 3 cycles per transaction (grant, ack, gap).
- Abandon: mx_req drops in GNTx before ack -> go to IDLE next cycle, no ack issued.
- Watchdog: wdog counts cycles spent in GNTx and clears on entry to GNTx.
  - When wdog reaches TIMEOUT_CYCLES-1 with no s_ack: pulse err, set err_src=x, go to GAP, no ack issued.
  - The requester must then drop req or it will be re-arbitrated.
- Watchdog width: wdog is $clog2(TIMEOUT_CYCLES+1) bits and saturates rather than wrapping.
- Lock boundary: m1_lock is ignored in IDLE; it never blocks m0 from winning an arbitration.
  - With lock held, m0 starves only while m1 keeps requesting.
- Reset mid-transaction: state returns to IDLE in the same edge and s_req drops. Any in-flight memory write may or may not have occurred.
- m0_we does not exist: writes from m0 are impossible by construction.

Decomposition:
- Shared package bfcpu_mem_pkg:
  - arbiter state encoding (IDLE=2'd0, GNT0=2'd1, GNT1=2'd2, GAP=2'd3);
  - requester IDs (REQ_FETCH=1'b0, REQ_LOADER=1'b1);
  - default ADDR_WIDTH/DATA_WIDTH constants.
- One natural sub-module: mem_watchdog (counter with clear, enable and terminal-count pulse), reusable for data memory.
- Arbitration, muxing and FSM stay in i_mem_arbiter.

Test Plan:
- Single fetch: m0_req=1, addr=16'h0010, memory acks 1 cycle after s_req.
  - Expected: s_req high from cycle 1; m0_ack at cycle 2 with m0_rdata = mem[0x10]; s_req=0 at cycle 3 (GAP).
- Contention: m0_req and m1_req both held from reset release.
  - Expected: grants alternate m0, m1, m0, m1; each transaction separated by one s_req=0 cycle; m1_ack never coincides with m0_ack.
- Loader write/readback: m1 writes 8'hA5 to addr 16'h0003 (m1_we=1), then reads it.
  - Expected: s_we=1 only during the write grant; read returns m1_rdata=8'hA5.
- Lock burst: m1_lock=1, m1 performs 4 writes to addrs 0..3 while m0_req=1.
  - Expected: state stays GNT1 throughout; m0_ack stays 0; after m1_lock=0 and m1_req=0, m0 is granted within 3 cycles.
- Timeout: TIMEOUT_CYCLES=8, memory never acks, m0_req held.
  - Expected: err pulses once 8 cycles after the grant; err_src=0; m0_ack stays 0.
- Reset mid-grant: assert rst during GNT1.
  - Expected: next cycle s_req=0 and state IDLE; after release with both requesting, m0 is granted first.

Source files
------------

// File: rtl/bfcpu_mem_pkg.sv
// Shared definitions for the instruction/data memory arbitration logic:
// arbiter state encoding, requester IDs and default bus widths.
package bfcpu_mem_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        GNT0 = 2'd1,
        GNT1 = 2'd2,
        GAP  = 2'd3
    } arb_state_e;

    // Requester IDs, also used as the encoding of the round-robin pointer
    // and of the error-source flag.
    localparam logic REQ_FETCH  = 1'b0;
    localparam logic REQ_LOADER = 1'b1;

    localparam int DEFAULT_ADDR_WIDTH = 16;
    localparam int DEFAULT_DATA_WIDTH = 8;

endpackage

// File: rtl/mem_watchdog.sv
// Saturating cycle counter with synchronous clear and count enable.
// tc flags the cycle in which the count sits at TIMEOUT_CYCLES-1 while
// enabled; TIMEOUT_CYCLES = 0 disables tc entirely.
module mem_watchdog #(
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic tc
);

    localparam int CNT_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] TC_VAL  = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Next count: clear wins, otherwise count up while enabled and saturate.
    always_comb begin
        // NOTE: every variable gets a default before any branch so no path
        // leaves it unassigned, which would otherwise infer a latch.
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en && (cnt_q != CNT_MAX)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // Counter register.
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments here so every flop samples the
        // pre-edge values, independent of statement order between blocks.
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tc = (TIMEOUT_CYCLES > 0) && en && (cnt_q == TC_VAL);

endmodule

// File: rtl/i_mem_arbiter.sv
// Instruction-memory arbiter: shares one memory port between the CPU fetch
// unit (m0, read-only) and the loader/debug port (m1, read/write). Round-robin
// arbitration, optional m1 burst lock, one forced idle cycle after every
// completed or aborted transaction, and a watchdog that aborts stuck grants.
module i_mem_arbiter
    import bfcpu_mem_pkg::*;
#(
    parameter int ADDR_WIDTH     = DEFAULT_ADDR_WIDTH,
    parameter int DATA_WIDTH     = DEFAULT_DATA_WIDTH,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  m0_req,
    input  logic [ADDR_WIDTH-1:0] m0_addr,
    output logic                  m0_ack,
    output logic [DATA_WIDTH-1:0] m0_rdata,
    input  logic                  m1_req,
    input  logic                  m1_we,
    input  logic                  m1_lock,
    input  logic [ADDR_WIDTH-1:0] m1_addr,
    input  logic [DATA_WIDTH-1:0] m1_wdata,
    output logic                  m1_ack,
    output logic [DATA_WIDTH-1:0] m1_rdata,
    output logic                  s_req,
    output logic                  s_we,
    output logic [ADDR_WIDTH-1:0] s_addr,
    output logic [DATA_WIDTH-1:0] s_wdata,
    input  logic                  s_ack,
    input  logic [DATA_WIDTH-1:0] s_rdata,
    output logic                  err,
    output logic                  err_src
);

    arb_state_e state_q, state_d;
    logic       last_q, last_d;        // requester granted most recently
    logic       err_q, err_d;
    logic       err_src_q, err_src_d;
    logic       lock_gap_q, lock_gap_d; // one-cycle req drop allowed after a locked ack

    logic in_gnt;
    logic done;
    logic wdog_tc;

    assign in_gnt = (state_q == GNT0) || (state_q == GNT1);
    // s_req is already forced low in reset, so done and the acks are too.
    assign done   = s_ack && s_req;

    mem_watchdog #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_wdog (
        .clk (clk),
        .rst (rst),
        .clr (!in_gnt || done),
        .en  (in_gnt),
        .tc  (wdog_tc)
    );

    // Memory-side mux and requester acks; everything idles low during reset.
    always_comb begin
        s_req   = 1'b0;
        s_we    = 1'b0;
        s_addr  = '0;
        s_wdata = '0;
        if (!rst) begin
            case (state_q)
                GNT0: begin
                    s_req  = m0_req;
                    s_addr = m0_addr;
                end
                GNT1: begin
                    s_req   = m1_req;
                    s_we    = m1_we;
                    s_addr  = m1_addr;
                    s_wdata = m1_wdata;
                end
                default: ;
            endcase
        end
        m0_ack = (state_q == GNT0) && done;
        m1_ack = (state_q == GNT1) && done;
    end

    assign m0_rdata = s_rdata;
    assign m1_rdata = s_rdata;

    // Arbitration and transaction sequencing.
    always_comb begin
        state_d    = state_q;
        last_d     = last_q;
        err_d      = 1'b0;
        err_src_d  = err_src_q;
        lock_gap_d = 1'b0;
        case (state_q)
            IDLE: begin
                // On contention the requester that did not go last wins.
                if (m0_req && (!m1_req || (last_q == REQ_LOADER))) begin
                    state_d = GNT0;
                    last_d  = REQ_FETCH;
                end else if (m1_req) begin
                    state_d = GNT1;
                    last_d  = REQ_LOADER;
                end
            end
            GNT0: begin
                if (done) begin
                    state_d = GAP;
                end else if (!m0_req) begin
                    state_d = IDLE;
                end else if (wdog_tc) begin
                    state_d   = GAP;
                    err_d     = 1'b1;
                    err_src_d = REQ_FETCH;
                end
            end
            GNT1: begin
                if (done) begin
                    // A locked burst keeps the grant; the loader supplies the
                    // idle cycle itself by dropping m1_req once.
                    if (m1_lock) begin
                        lock_gap_d = 1'b1;
                    end else begin
                        state_d = GAP;
                    end
                end else if (!m1_req) begin
                    if (!(lock_gap_q && m1_lock)) begin
                        state_d = IDLE;
                    end
                end else if (wdog_tc) begin
                    state_d   = GAP;
                    err_d     = 1'b1;
                    err_src_d = REQ_LOADER;
                end
            end
            GAP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State registers; last resets to the loader so fetch wins first.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            last_q     <= REQ_LOADER;
            err_q      <= 1'b0;
            err_src_q  <= REQ_FETCH;
            lock_gap_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            last_q     <= last_d;
            err_q      <= err_d;
            err_src_q  <= err_src_d;
            lock_gap_q <= lock_gap_d;
        end
    end

    assign err     = err_q;
    assign err_src = err_src_q;

endmodule

// File: tb/tb_i_mem_arbiter.sv
// Directed bench for i_mem_arbiter with a one-cycle-latency memory model.
module tb_i_mem_arbiter;

    logic        clk;
    logic        rst;
    logic        m0_req;
    logic [15:0] m0_addr;
    logic        m0_ack;
    logic [7:0]  m0_rdata;
    logic        m1_req;
    logic        m1_we;
    logic        m1_lock;
    logic [15:0] m1_addr;
    logic [7:0]  m1_wdata;
    logic        m1_ack;
    logic [7:0]  m1_rdata;
    logic        s_req;
    logic        s_we;
    logic [15:0] s_addr;
    logic [7:0]  s_wdata;
    logic        s_ack;
    logic [7:0]  s_rdata;
    logic        err;
    logic        err_src;

    // Memory model: registered ready that rises one cycle after s_req and
    // falls the cycle after it was high; contents are preset to addr ^ 8'h5A.
    logic        mem_en;
    logic        rdy;
    logic [7:0]  mem [0:255];

    int n_checks = 0;
    int n_pass   = 0;
    int n_fail   = 0;

    i_mem_arbiter #(
        .ADDR_WIDTH    (16),
        .DATA_WIDTH    (8),
        .TIMEOUT_CYCLES(8)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .m0_req   (m0_req),
        .m0_addr  (m0_addr),
        .m0_ack   (m0_ack),
        .m0_rdata (m0_rdata),
        .m1_req   (m1_req),
        .m1_we    (m1_we),
        .m1_lock  (m1_lock),
        .m1_addr  (m1_addr),
        .m1_wdata (m1_wdata),
        .m1_ack   (m1_ack),
        .m1_rdata (m1_rdata),
        .s_req    (s_req),
        .s_we     (s_we),
        .s_addr   (s_addr),
        .s_wdata  (s_wdata),
        .s_ack    (s_ack),
        .s_rdata  (s_rdata),
        .err      (err),
        .err_src  (err_src)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign s_ack   = rdy && s_req;
    assign s_rdata = mem[s_addr[7:0]];

    always @(posedge clk) begin
        if (rst) begin
            rdy <= 1'b0;
            for (int i = 0; i < 256; i++) mem[i] <= 8'(i) ^ 8'h5A;
        end else begin
            rdy <= s_req && mem_en && !rdy;
            if (s_ack && s_we) mem[s_addr[7:0]] <= s_wdata;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic smp();
        @(negedge clk);
    endtask

    initial begin
        #50000;
        $display("FAIL global_timeout: bench did not reach its summary");
        $fatal(1, "bench time limit reached");
    end

    initial begin
        rst = 1'b1; m0_req = 1'b0; m0_addr = '0; m1_req = 1'b0; m1_we = 1'b0;
        m1_lock = 1'b0; m1_addr = '0; m1_wdata = '0; mem_en = 1'b1;

        // Reset state
        next_cycle(); next_cycle(); smp();
        check("rst_s_req",   32'(s_req),   0);
        check("rst_m0_ack",  32'(m0_ack),  0);
        check("rst_m1_ack",  32'(m1_ack),  0);
        check("rst_err",     32'(err),     0);
        check("rst_err_src", 32'(err_src), 0);

        // Single fetch from 0x0010
        next_cycle(); rst = 1'b0; m0_req = 1'b1; m0_addr = 16'h0010; smp();
        check("fetch_idle_s_req", 32'(s_req), 0);
        next_cycle(); smp();
        check("fetch_s_req",  32'(s_req),  1);
        check("fetch_s_addr", 32'(s_addr), 32'h0010);
        check("fetch_s_we",   32'(s_we),   0);
        check("fetch_early_ack", 32'(m0_ack), 0);
        next_cycle(); smp();
        check("fetch_m0_ack",   32'(m0_ack),   1);
        check("fetch_m0_rdata", 32'(m0_rdata), 32'h4A);
        check("fetch_m1_iso",   32'(m1_ack),   0);
        next_cycle(); m0_req = 1'b0; smp();
        check("fetch_gap_s_req", 32'(s_req), 0);
        next_cycle(); rst = 1'b1; smp();

        // Contention from reset release: m0, m1, m0, m1
        next_cycle(); rst = 1'b0; m0_req = 1'b1; m1_req = 1'b1;
        m1_we = 1'b0; m1_addr = 16'h0020; smp();
        for (int k = 0; k < 4; k++) begin
            next_cycle(); smp();
            check("cont_s_req",  32'(s_req), 1);
            check("cont_s_addr", 32'(s_addr), (k % 2 == 0) ? 32'h0010 : 32'h0020);
            next_cycle(); smp();
            check("cont_m0_ack", 32'(m0_ack), (k % 2 == 0) ? 1 : 0);
            check("cont_m1_ack", 32'(m1_ack), (k % 2 == 0) ? 0 : 1);
            check("cont_rdata",  (k % 2 == 0) ? 32'(m0_rdata) : 32'(m1_rdata),
                  (k % 2 == 0) ? 32'h4A : 32'h7A);
            next_cycle(); if (k == 3) begin m0_req = 1'b0; m1_req = 1'b0; end smp();
            check("cont_gap_s_req", 32'(s_req), 0);
            next_cycle(); smp();
            check("cont_idle_s_req", 32'(s_req), 0);
        end

        // Loader write 0xA5 to 0x0003, then read it back
        next_cycle(); m1_req = 1'b1; m1_we = 1'b1; m1_addr = 16'h0003; m1_wdata = 8'hA5; smp();
        next_cycle(); smp();
        check("wr_s_req",   32'(s_req),   1);
        check("wr_s_we",    32'(s_we),    1);
        check("wr_s_addr",  32'(s_addr),  32'h0003);
        check("wr_s_wdata", 32'(s_wdata), 32'hA5);
        next_cycle(); smp();
        check("wr_m1_ack", 32'(m1_ack), 1);
        check("wr_m0_iso", 32'(m0_ack), 0);
        next_cycle(); m1_we = 1'b0; smp();
        check("wr_gap_s_we",  32'(s_we),  0);
        check("wr_gap_s_req", 32'(s_req), 0);
        next_cycle(); smp();
        next_cycle(); smp();
        check("rd_s_req", 32'(s_req), 1);
        check("rd_s_we",  32'(s_we),  0);
        next_cycle(); smp();
        check("rd_m1_ack",   32'(m1_ack),   1);
        check("rd_m1_rdata", 32'(m1_rdata), 32'hA5);
        next_cycle(); m1_req = 1'b0; smp();
        next_cycle(); smp();

        // Locked burst: four m1 writes to 0..3 while m0 keeps requesting
        next_cycle(); m1_req = 1'b1; m1_lock = 1'b1; m1_we = 1'b1;
        m1_addr = 16'h0000; m1_wdata = 8'hC0; smp();
        for (int i = 0; i < 4; i++) begin
            next_cycle(); m1_req = 1'b1; m0_req = 1'b1; m0_addr = 16'h0010; smp();
            check("lock_s_req",  32'(s_req),  1);
            check("lock_s_addr", 32'(s_addr), 32'(i));
            check("lock_m0_starve", 32'(m0_ack), 0);
            next_cycle(); smp();
            check("lock_m1_ack", 32'(m1_ack), 1);
            check("lock_m0_iso", 32'(m0_ack), 0);
            next_cycle(); m1_req = 1'b0;
            if (i == 3) m1_lock = 1'b0;
            else begin m1_addr = 16'(i + 1); m1_wdata = 8'(8'hC0 + i + 1); end
            smp();
            check("lock_drop_s_req", 32'(s_req), 0);
        end
        next_cycle(); smp();
        check("unlock_idle_s_req", 32'(s_req), 0);
        next_cycle(); smp();
        check("unlock_m0_s_req",  32'(s_req),  1);
        check("unlock_m0_s_addr", 32'(s_addr), 32'h0010);
        next_cycle(); smp();
        check("unlock_m0_ack", 32'(m0_ack), 1);
        check("lock_mem1", 32'(mem[1]), 32'hC1);
        check("lock_mem3", 32'(mem[3]), 32'hC3);
        next_cycle(); m0_req = 1'b0; m1_we = 1'b0; smp();
        next_cycle(); smp();

        // Watchdog: memory stops acking, m0 times out after 8 grant cycles
        next_cycle(); mem_en = 1'b0; m0_req = 1'b1; smp();
        for (int j = 0; j < 8; j++) begin
            next_cycle(); smp();
            check("to0_s_req",  32'(s_req),  1);
            check("to0_no_ack", 32'(m0_ack), 0);
            check("to0_no_err", 32'(err),    0);
        end
        next_cycle(); m0_req = 1'b0; smp();
        check("to0_err",     32'(err),     1);
        check("to0_err_src", 32'(err_src), 0);
        check("to0_gap",     32'(s_req),   0);
        next_cycle(); m1_req = 1'b1; m1_addr = 16'h0020; smp();
        check("to0_err_once", 32'(err), 0);
        for (int j = 0; j < 8; j++) begin
            next_cycle(); smp();
            check("to1_no_ack", 32'(m1_ack), 0);
            check("to1_no_err", 32'(err),    0);
        end
        next_cycle(); m1_req = 1'b0; smp();
        check("to1_err",     32'(err),     1);
        check("to1_err_src", 32'(err_src), 1);
        next_cycle(); smp();
        check("to1_err_once",    32'(err),     0);
        check("to1_err_src_hold", 32'(err_src), 1);

        // Reset during a GNT1 grant, then contention after release
        next_cycle(); mem_en = 1'b1; m1_req = 1'b1; smp();
        next_cycle(); smp();
        check("rmid_gnt1_s_req", 32'(s_req), 1);
        next_cycle(); rst = 1'b1; smp();
        check("rmid_rst_s_req",  32'(s_req),  0);
        check("rmid_rst_m1_ack", 32'(m1_ack), 0);
        next_cycle(); rst = 1'b0; m0_req = 1'b1; m0_addr = 16'h0010; smp();
        check("rmid_idle_s_req", 32'(s_req),   0);
        check("rmid_err_src",    32'(err_src), 0);
        next_cycle(); smp();
        check("rmid_m0_first_req",  32'(s_req),  1);
        check("rmid_m0_first_addr", 32'(s_addr), 32'h0010);
        next_cycle(); smp();
        check("rmid_m0_ack", 32'(m0_ack), 1);
        check("rmid_m1_iso", 32'(m1_ack), 0);
        next_cycle(); m0_req = 1'b0; m1_req = 1'b0; smp();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
